regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back sequencer that drives the register file's write port (`wr`/`Addr_D`/`Data_D`) from two result sources: single-cycle ALU results and multi-cycle load returns.

- Keeps an in-order FIFO of outstanding load destinations and a 32-bit busy scoreboard.
- Arbitrates the single write port between the two sources.
- Raises read-hazard flags for the decode stage.
- Sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `DWIDTH`, 32, data width; matches the register file.
- `DEPTH`, 4, maximum outstanding loads (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  DWIDTH  ALU result.
- `ld_issue`  in  1  load issued; reserve `ld_issue_rd`.
- `ld_issue_ready`  out  1  load issue accepted.
- `ld_issue_rd`  in  5  load destination register.
- `ld_valid`  in  1  load data returning (in issue order).
- `ld_data`  in  DWIDTH  returned load data.
- `rs_a`, `rs_b`  in  5 each  decode-stage source registers.
- `hz_a`, `hz_b`  out  1 each  source register has a pending load.
- `wr`  out  1  register-file write enable.
- `Addr_D`  out  5  write address.
- `Data_D`  out  DWIDTH  write data.
- `ld_pending`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `err`  out  1  sticky protocol error.

## Operation
Write-port selection (combinational):
- If `ld_valid` and FIFO not empty: the load response wins.
  - `Addr_D` = FIFO head rd, `Data_D` = `ld_data`, `wr` = (head rd ≠ 0).
  - FIFO pops.
  - Busy bit for head rd clears, unless the same rd is issued this cycle (set wins).
- Else if `alu_valid && alu_ready`: `Addr_D` = `alu_rd`, `Data_D` = `alu_data`, `wr` = (`alu_rd` ≠ 0).
- Else `wr` = 0, `Addr_D` = 0, `Data_D` = 0.

Handshakes and hazards:
- `alu_ready` = !rst && !(`ld_valid` && !empty) && !(busy[`alu_rd`] && `alu_rd` ≠ 0). This blocks write-after-write over a pending load.
- `ld_issue_ready` = !rst && (!full || (`ld_valid` && !empty)). A simultaneous pop frees a slot.
- Accepted issue: push rd; set busy[rd] if rd ≠ 0. rd = 0 is still pushed to preserve response order.
- `hz_a` = busy[`rs_a`], `hz_b` = busy[`rs_b`]; busy[0] is constantly 0.

Boundary conditions:
- `ld_valid` with FIFO empty: ignored (no write, no pop); `err` sets and holds until `rst`.
- `ld_issue` while not ready: dropped; issuer must hold it.
- Same-cycle issue and return to the same rd: the old entry retires and writes; busy stays set for the new entry.
- Two outstanding loads to the same rd: busy stays set until the last of them retires. Track this with a per-register pending count, or by searching FIFO contents.

## Timing
- All outputs are combinational from inputs plus state.
- The write reaches the register file in the same cycle, at its falling-edge write.
- Zero-latency write for both sources.
- Load issue to earliest retirement: 1 cycle (return in the cycle after issue).
- Busy set is visible on `hz_*` the cycle after issue. It is cleared the cycle after retirement, at the rising edge following the write.
- Reset: FIFO empty, busy = 0, `err` = 0, `ld_pending` = 0, `wr` = 0.
  - While `rst` is high: `alu_ready` = 0 and `ld_issue_ready` = 0.
  - Reset mid-operation discards all outstanding loads; later responses flag `err`.

## Configuration
- Macro: `REGFILE_WB_PERF_EN`.
- Defined: adds outputs `wb_count` [31:0] (cycles with `wr` = 1) and `alu_stall_count` [31:0] (cycles with `alu_valid && !alu_ready`).
  - Both are free-running, wrap at 2^32, and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `regfile_wb_pkg`:
  - Constants `REG_AW` = 5 and `NUM_REGS` = 32.
  - Typedef `reg_addr_t` (logic [4:0]).
  - Typedef `busy_vec_t` (logic [31:0]).
- Sub-module `wb_rd_fifo`: `DEPTH` × 5-bit synchronous FIFO.
  - Ports: push, pop, head, full, empty, count.
  - Supports push while full when pop occurs in the same cycle.

## Test plan
- Reset, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 → same cycle `wr`=1, `Addr_D`=5, `Data_D`=0x1234, `alu_ready`=1.
- Issue load rd=7; next cycle `rs_a`=7 → `hz_a`=1. Then `ld_valid`, `ld_data`=0xCAFE → `wr`=1, `Addr_D`=7; the following cycle `hz_a`=0.
- Pending load rd=3 with `alu_valid` `alu_rd`=3 → `alu_ready`=0 until retirement. Same cycle as `ld_valid` with `alu_rd`=9 → load writes, ALU stalled one cycle.
- Issue 4 loads (DEPTH=4) → `ld_issue_ready`=0, `ld_pending`=4. A fifth issue concurrent with `ld_valid` → accepted, `ld_pending` stays 4.
- Load to rd=0 issued and returned → `wr`=0, no busy bit set, FIFO pops. `ld_valid` with empty FIFO → `err`=1, held until `rst`.
- `REGFILE_WB_PERF_EN` defined: 10 writes and 3 stall cycles → `wb_count`=10, `alu_stall_count`=3. Both return to 0 after `rst`.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared register-file addressing types for the write-back sequencer.
package regfile_wb_pkg;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [NUM_REGS-1:0] busy_vec_t;
endpackage

// File: rtl/wb_rd_fifo.sv
// In-order FIFO of outstanding load destination registers.
module wb_rd_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  reg_addr_t                  push_rd,
    input  logic                       pop,
    output reg_addr_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    reg_addr_t     mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_rd;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop)
                rptr <= rptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Write-back sequencer arbitrating the register-file write port between ALU and load returns.
// Optional performance counters are enabled with REGFILE_WB_PERF_EN.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REG_AW-1:0]          alu_rd,
    input  logic [DWIDTH-1:0]          alu_data,
    input  logic                       ld_issue,
    output logic                       ld_issue_ready,
    input  logic [REG_AW-1:0]          ld_issue_rd,
    input  logic                       ld_valid,
    input  logic [DWIDTH-1:0]          ld_data,
    input  logic [REG_AW-1:0]          rs_a,
    input  logic [REG_AW-1:0]          rs_b,
    output logic                       hz_a,
    output logic                       hz_b,
    output logic                       wr,
    output logic [REG_AW-1:0]          Addr_D,
    output logic [DWIDTH-1:0]          Data_D,
    output logic [$clog2(DEPTH+1)-1:0] ld_pending,
    output logic                       err
`ifdef REGFILE_WB_PERF_EN
    ,
    output logic [31:0]                wb_count,
    output logic [31:0]                alu_stall_count
`endif
);
    localparam int CW = $clog2(DEPTH+1);

    reg_addr_t     head;
    logic          full, empty;
    logic          ld_win, alu_acc, issue_acc;
    busy_vec_t     busy;
    logic [CW-1:0] pend_cnt [NUM_REGS];

    assign ld_win         = !rst && ld_valid && !empty;
    assign alu_ready      = !rst && !ld_win && !(busy[alu_rd] && alu_rd != '0);
    assign alu_acc        = alu_valid && alu_ready;
    assign ld_issue_ready = !rst && (!full || ld_win);
    assign issue_acc      = ld_issue && ld_issue_ready;

    wb_rd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue_acc),
        .push_rd (ld_issue_rd),
        .pop     (ld_win),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (ld_pending)
    );

    always_comb begin
        wr     = 1'b0;
        Addr_D = '0;
        Data_D = '0;
        if (ld_win) begin
            wr     = (head != '0);
            Addr_D = head;
            Data_D = ld_data;
        end else if (alu_acc) begin
            wr     = (alu_rd != '0);
            Addr_D = alu_rd;
            Data_D = alu_data;
        end
    end

    // Per-register outstanding-load count; same-cycle issue and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                pend_cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if ((issue_acc && ld_issue_rd == REG_AW'(r)) && !(ld_win && head == REG_AW'(r)))
                    pend_cnt[r] <= pend_cnt[r] + CW'(1);
                else if (!(issue_acc && ld_issue_rd == REG_AW'(r)) && (ld_win && head == REG_AW'(r)))
                    pend_cnt[r] <= pend_cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++)
            busy[r] = (pend_cnt[r] != '0);
    end

    assign hz_a = busy[rs_a];
    assign hz_b = busy[rs_b];

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (ld_valid && empty)
            err <= 1'b1;
    end

`ifdef REGFILE_WB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count        <= '0;
            alu_stall_count <= '0;
        end else begin
            if (wr)
                wb_count <= wb_count + 32'd1;
            if (alu_valid && !alu_ready)
                alu_stall_count <= alu_stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DWIDTH=32, DEPTH=4).
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue, ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  rs_a, rs_b;
    logic        hz_a, hz_b, wr;
    logic [4:0]  Addr_D;
    logic [31:0] Data_D;
    logic [2:0]  ld_pending;
    logic        err;
`ifdef REGFILE_WB_PERF_EN
    logic [31:0] wb_count, alu_stall_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    regfile_writeback #(.DWIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .rs_a(rs_a), .rs_b(rs_b), .hz_a(hz_a), .hz_b(hz_b),
        .wr(wr), .Addr_D(Addr_D), .Data_D(Data_D),
        .ld_pending(ld_pending), .err(err)
`ifdef REGFILE_WB_PERF_EN
        , .wb_count(wb_count), .alu_stall_count(alu_stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and clear all stimulus.
    task automatic cyc();
        @(posedge clk);
        #1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_data = 0;
        rs_a = 0; rs_b = 0;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1;
        cyc();
        alu_valid = 1; alu_rd = 5; ld_issue = 1; ld_issue_rd = 2; settle();
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_issue_ready", ld_issue_ready, 0);
        chk("rst_wr", wr, 0);
        cyc(); settle();
        chk("rst_pending", ld_pending, 0);
        chk("rst_err", err, 0);
        rst = 0;
        cyc();
        // ALU write, zero latency
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; settle();
        chk("alu_wr", wr, 1); chk("alu_addr", Addr_D, 5);
        chk("alu_data", Data_D, 32'h1234); chk("alu_ready", alu_ready, 1);
        cyc();
        ld_issue = 1; ld_issue_rd = 7; settle();
        chk("issue7_ready", ld_issue_ready, 1); chk("idle_wr", wr, 0); chk("idle_addr", Addr_D, 0);
        cyc();
        rs_a = 7; rs_b = 7; settle();
        chk("hz_a_7", hz_a, 1); chk("hz_b_7", hz_b, 1); chk("pending_1", ld_pending, 1);
        cyc();
        ld_valid = 1; ld_data = 32'hCAFE; rs_a = 7; settle();
        chk("ld7_wr", wr, 1); chk("ld7_addr", Addr_D, 7); chk("ld7_data", Data_D, 32'hCAFE);
        chk("ld7_hz_still", hz_a, 1);
        cyc();
        rs_a = 7; settle();
        chk("ld7_hz_clear", hz_a, 0); chk("pending_0", ld_pending, 0);
        // WAW block on pending load to r3
        cyc();
        ld_issue = 1; ld_issue_rd = 3;
        cyc();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33; settle();
        chk("waw_ready", alu_ready, 0); chk("waw_wr", wr, 0);
        cyc();
        ld_valid = 1; ld_data = 32'h3333; alu_valid = 1; alu_rd = 9; alu_data = 32'h99; settle();
        chk("arb_addr", Addr_D, 3); chk("arb_data", Data_D, 32'h3333); chk("arb_alu_stall", alu_ready, 0);
        cyc();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; settle();
        chk("alu9_ready", alu_ready, 1); chk("alu9_addr", Addr_D, 9); chk("alu9_data", Data_D, 32'h99);
        cyc();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3; settle();
        chk("alu3_ready", alu_ready, 1); chk("alu3_wr", wr, 1);
        // Fill the FIFO
        for (int i = 0; i < 4; i++) begin
            cyc();
            ld_issue = 1; ld_issue_rd = 5'(10 + i); settle();
            chk("fill_ready", ld_issue_ready, 1);
        end
        cyc();
        ld_issue = 1; ld_issue_rd = 14; alu_valid = 1; alu_rd = 11; settle();
        chk("full_ready", ld_issue_ready, 0); chk("full_pending", ld_pending, 4);
        chk("busy11_stall", alu_ready, 0);
        cyc();
        ld_issue = 1; ld_issue_rd = 14; ld_valid = 1; ld_data = 32'hA; settle();
        chk("full_pop_ready", ld_issue_ready, 1); chk("full_pop_addr", Addr_D, 10);
        cyc();
        rs_a = 10; rs_b = 14; settle();
        chk("full_pending_keep", ld_pending, 4); chk("hz10_clear", hz_a, 0); chk("hz14_set", hz_b, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            ld_valid = 1; ld_data = 32'(i); settle();
            chk("drain_addr", Addr_D, 32'(11 + i)); chk("drain_wr", wr, 1);
        end
        cyc();
        rs_b = 14; settle();
        chk("drain_pending", ld_pending, 0); chk("hz14_clear", hz_b, 0);
`ifdef REGFILE_WB_PERF_EN
        chk("wb_count", wb_count, 10); chk("alu_stall_count", alu_stall_count, 3);
`endif
        // Overlapping loads to r6, including issue concurrent with retire
        ld_issue = 1; ld_issue_rd = 6;
        cyc();
        ld_issue = 1; ld_issue_rd = 6;
        cyc();
        ld_valid = 1; ld_data = 32'h61; ld_issue = 1; ld_issue_rd = 6; settle();
        chk("r6_first_addr", Addr_D, 6);
        cyc();
        rs_a = 6; settle();
        chk("r6_hz_a", hz_a, 1); chk("r6_pending", ld_pending, 2);
        ld_valid = 1;
        cyc();
        rs_a = 6; ld_valid = 1; settle();
        chk("r6_hz_last", hz_a, 1); chk("r6_last_addr", Addr_D, 6);
        cyc();
        rs_a = 6; settle();
        chk("r6_hz_clear", hz_a, 0); chk("r6_pending0", ld_pending, 0);
        // Load to r0
        ld_issue = 1; ld_issue_rd = 0;
        cyc();
        rs_a = 0; settle();
        chk("r0_hz", hz_a, 0); chk("r0_pending", ld_pending, 1);
        ld_valid = 1; ld_data = 32'hFF; settle();
        chk("r0_wr", wr, 0);
        cyc();
        settle();
        chk("r0_popped", ld_pending, 0); chk("no_err_yet", err, 0);
        ld_valid = 1; ld_data = 32'h5; settle();
        chk("empty_ld_wr", wr, 0);
        cyc();
        settle();
        chk("err_set", err, 1);
        cyc(); cyc();
        settle();
        chk("err_held", err, 1);
        rst = 1;
        cyc();
        alu_valid = 1; alu_rd = 1; settle();
        chk("rst2_alu_ready", alu_ready, 0);
        rst = 0;
        cyc();
        settle();
        chk("rst2_err", err, 0);
`ifdef REGFILE_WB_PERF_EN
        chk("wb_count_rst", wb_count, 0); chk("stall_count_rst", alu_stall_count, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
